// File: rtl/banked_dpram_pkg.sv
// ---------------------------------------------------------------------------
// banked_dpram_pkg : shared constants and helper functions for banked_dpram.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package banked_dpram_pkg;

  // Ceiling log2, usable in constant expressions.
  function automatic int log2(input int v);
    int r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  localparam int DEF_NUM_BANKS       = 8;
  localparam int DEF_BANK_ADDR_WIDTH = 13;
  localparam int DEF_DATA_WIDTH      = 32;
  localparam int DEF_CNT_WIDTH       = 16;

  // The read mux is written once for the largest supported geometry;
  // unused entries are tied to zero and optimise away.
  localparam int MAX_BANKS     = 64;
  localparam int MAX_DW        = 256;
  localparam int MAX_BANK_BITS = log2(MAX_BANKS);

  function automatic logic [MAX_DW-1:0] do_mux(
    input logic [MAX_BANKS-1:0][MAX_DW-1:0] words,
    input logic [MAX_BANK_BITS-1:0]         sel,
    input logic                             vld
  );
    return vld ? words[sel] : '0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/banked_dpram_bank.sv
// ---------------------------------------------------------------------------
// banked_dpram_bank : one true dual-port, byte-write, synchronous-read RAM bank.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module banked_dpram_bank #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      i_ce_a,
  input  logic                      i_we_a,
  input  logic [DATA_WIDTH/8-1:0]   i_be_a,
  input  logic [ADDR_WIDTH-1:0]     i_addr_a,
  input  logic [DATA_WIDTH-1:0]     i_wdata_a,
  output logic [DATA_WIDTH-1:0]     o_rdata_a,
  input  logic                      i_ce_b,
  input  logic                      i_we_b,
  input  logic [DATA_WIDTH/8-1:0]   i_be_b,
  input  logic [ADDR_WIDTH-1:0]     i_addr_b,
  input  logic [DATA_WIDTH-1:0]     i_wdata_b,
  output logic [DATA_WIDTH-1:0]     o_rdata_b
);

  localparam int NBYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_a_q;
  logic [DATA_WIDTH-1:0] rdata_b_q;

  // Port A lanes are written last so they take priority on a shared lane;
  // reads return the pre-write contents, forwarding is done by the caller.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NBYTES; i++) begin
      if (i_ce_b && i_we_b && i_be_b[i]) mem_q[i_addr_b][i*8 +: 8] <= i_wdata_b[i*8 +: 8];
    end
    for (int i = 0; i < NBYTES; i++) begin
      if (i_ce_a && i_we_a && i_be_a[i]) mem_q[i_addr_a][i*8 +: 8] <= i_wdata_a[i*8 +: 8];
    end
    if (i_ce_a && !i_we_a) rdata_a_q <= mem_q[i_addr_a];
    if (i_ce_b && !i_we_b) rdata_b_q <= mem_q[i_addr_b];
  end

  assign o_rdata_a = rdata_a_q;
  assign o_rdata_b = rdata_b_q;

endmodule

`default_nettype wire

// File: rtl/banked_dpram.sv
// ---------------------------------------------------------------------------
// banked_dpram : banked dual-port RAM with write-first forwarding and a
// saturating collision counter. Define OUTREG_EN for a 2-cycle read. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module banked_dpram
  import banked_dpram_pkg::*;
#(
  parameter int NUM_BANKS       = DEF_NUM_BANKS,
  parameter int BANK_ADDR_WIDTH = DEF_BANK_ADDR_WIDTH,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH       = DEF_CNT_WIDTH,
  localparam int BANK_BITS      = log2(NUM_BANKS),
  localparam int ADDR_WIDTH     = BANK_BITS + BANK_ADDR_WIDTH,
  localparam int NBYTES         = DATA_WIDTH / 8
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  CSA,
  input  logic                  WEA,
  input  logic [NBYTES-1:0]     BWA,
  input  logic [ADDR_WIDTH-1:0] ADDRA,
  input  logic [DATA_WIDTH-1:0] DIA,
  output logic [DATA_WIDTH-1:0] DOA,
  output logic                  RVALIDA,
  input  logic                  CSB,
  input  logic                  WEB,
  input  logic [NBYTES-1:0]     BWB,
  input  logic [ADDR_WIDTH-1:0] ADDRB,
  input  logic [DATA_WIDTH-1:0] DIB,
  output logic [DATA_WIDTH-1:0] DOB,
  output logic                  RVALIDB,
  input  logic                  CLRCNT,
  output logic                  COLL,
  output logic [CNT_WIDTH-1:0]  COLLCNT
);

  logic                 rd_a, wr_a, rd_b, wr_b, same_addr;
  logic [BANK_BITS-1:0] bank_a, bank_b;
  logic [NBYTES-1:0]    bwb_eff;

  always_comb begin
    rd_a      = CSA & ~WEA;
    wr_a      = CSA & WEA & (|BWA);
    rd_b      = CSB & ~WEB;
    wr_b      = CSB & WEB & (|BWB);
    same_addr = (ADDRA == ADDRB);
    bank_a    = ADDRA[ADDR_WIDTH-1:BANK_ADDR_WIDTH];
    bank_b    = ADDRB[ADDR_WIDTH-1:BANK_ADDR_WIDTH];
    // Shared lanes belong to port A, so B's enables are trimmed there.
    bwb_eff   = (wr_a && same_addr) ? (BWB & ~BWA) : BWB;
  end

  logic [DATA_WIDTH-1:0] rdata_a [NUM_BANKS];
  logic [DATA_WIDTH-1:0] rdata_b [NUM_BANKS];

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    logic ce_a, ce_b;
    assign ce_a = (rd_a | wr_a) && (bank_a == BANK_BITS'(g));
    assign ce_b = (rd_b | wr_b) && (bank_b == BANK_BITS'(g));

    banked_dpram_bank #(
      .ADDR_WIDTH (BANK_ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_bank (
      .clk       (HCLK),
      .i_ce_a    (ce_a),
      .i_we_a    (WEA),
      .i_be_a    (BWA),
      .i_addr_a  (ADDRA[BANK_ADDR_WIDTH-1:0]),
      .i_wdata_a (DIA),
      .o_rdata_a (rdata_a[g]),
      .i_ce_b    (ce_b),
      .i_we_b    (WEB),
      .i_be_b    (bwb_eff),
      .i_addr_b  (ADDRB[BANK_ADDR_WIDTH-1:0]),
      .i_wdata_b (DIB),
      .o_rdata_b (rdata_b[g])
    );
  end

  logic                  rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;
  logic [BANK_BITS-1:0]  bank_sel_a_q, bank_sel_a_d, bank_sel_b_q, bank_sel_b_d;
  logic [NBYTES-1:0]     fwd_mask_a_q, fwd_mask_a_d, fwd_mask_b_q, fwd_mask_b_d;
  logic [DATA_WIDTH-1:0] fwd_data_a_q, fwd_data_a_d, fwd_data_b_q, fwd_data_b_d;
  logic                  coll_q, coll_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  always_comb begin
    rvalid_a_d   = rd_a;
    rvalid_b_d   = rd_b;
    bank_sel_a_d = rd_a ? bank_a : bank_sel_a_q;
    bank_sel_b_d = rd_b ? bank_b : bank_sel_b_q;
    // A read only ever sees the opposite port's write, so no trimming applies.
    fwd_mask_a_d = (rd_a && wr_b && same_addr) ? BWB : '0;
    fwd_mask_b_d = (rd_b && wr_a && same_addr) ? BWA : '0;
    fwd_data_a_d = DIB;
    fwd_data_b_d = DIA;
    coll_d       = wr_a & wr_b & same_addr & (|(BWA & BWB));
    cnt_d        = cnt_q;
    if (CLRCNT)                     cnt_d = '0;
    else if (coll_d && cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rvalid_a_q   <= 1'b0;
      rvalid_b_q   <= 1'b0;
      bank_sel_a_q <= '0;
      bank_sel_b_q <= '0;
      fwd_mask_a_q <= '0;
      fwd_mask_b_q <= '0;
      fwd_data_a_q <= '0;
      fwd_data_b_q <= '0;
      coll_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      rvalid_a_q   <= rvalid_a_d;
      rvalid_b_q   <= rvalid_b_d;
      bank_sel_a_q <= bank_sel_a_d;
      bank_sel_b_q <= bank_sel_b_d;
      fwd_mask_a_q <= fwd_mask_a_d;
      fwd_mask_b_q <= fwd_mask_b_d;
      fwd_data_a_q <= fwd_data_a_d;
      fwd_data_b_q <= fwd_data_b_d;
      coll_q       <= coll_d;
      cnt_q        <= cnt_d;
    end
  end

  logic [MAX_BANKS-1:0][MAX_DW-1:0] words_a, words_b;
  logic [DATA_WIDTH-1:0]            raw_a, raw_b, do_a_d, do_b_d;

  always_comb begin
    words_a = '0;
    words_b = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      words_a[b] = MAX_DW'(rdata_a[b]);
      words_b[b] = MAX_DW'(rdata_b[b]);
    end
    raw_a = DATA_WIDTH'(do_mux(words_a, MAX_BANK_BITS'(bank_sel_a_q), rvalid_a_q));
    raw_b = DATA_WIDTH'(do_mux(words_b, MAX_BANK_BITS'(bank_sel_b_q), rvalid_b_q));
    for (int i = 0; i < NBYTES; i++) begin
      do_a_d[i*8 +: 8] = fwd_mask_a_q[i] ? fwd_data_a_q[i*8 +: 8] : raw_a[i*8 +: 8];
      do_b_d[i*8 +: 8] = fwd_mask_b_q[i] ? fwd_data_b_q[i*8 +: 8] : raw_b[i*8 +: 8];
    end
  end

`ifdef OUTREG_EN
  logic [DATA_WIDTH-1:0] do_a_q, do_b_q;
  logic                  rvalid_o_a_q, rvalid_o_b_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      do_a_q       <= '0;
      do_b_q       <= '0;
      rvalid_o_a_q <= 1'b0;
      rvalid_o_b_q <= 1'b0;
    end else begin
      do_a_q       <= do_a_d;
      do_b_q       <= do_b_d;
      rvalid_o_a_q <= rvalid_a_q;
      rvalid_o_b_q <= rvalid_b_q;
    end
  end

  assign DOA     = do_a_q;
  assign DOB     = do_b_q;
  assign RVALIDA = rvalid_o_a_q;
  assign RVALIDB = rvalid_o_b_q;
`else
  assign DOA     = do_a_d;
  assign DOB     = do_b_d;
  assign RVALIDA = rvalid_a_q;
  assign RVALIDB = rvalid_b_q;
`endif

  assign COLL    = coll_q;
  assign COLLCNT = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_banked_dpram.sv
// ---------------------------------------------------------------------------
// tb_banked_dpram : scoreboard bench for banked_dpram (either OUTREG_EN build).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_banked_dpram;

  localparam int NB  = 8;
  localparam int BAW = 13;
  localparam int DW  = 32;
  localparam int CW  = 4;
  localparam int AW  = 16;
  localparam int NBY = 4;
`ifdef OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic           HCLK, HRESETn;
  logic           CSA, WEA, CSB, WEB, CLRCNT;
  logic [NBY-1:0] BWA, BWB;
  logic [AW-1:0]  ADDRA, ADDRB;
  logic [DW-1:0]  DIA, DIB, DOA, DOB;
  logic           RVALIDA, RVALIDB, COLL;
  logic [CW-1:0]  COLLCNT;

  banked_dpram #(
    .NUM_BANKS       (NB),
    .BANK_ADDR_WIDTH (BAW),
    .DATA_WIDTH      (DW),
    .CNT_WIDTH       (CW)
  ) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .CSA     (CSA),
    .WEA     (WEA),
    .BWA     (BWA),
    .ADDRA   (ADDRA),
    .DIA     (DIA),
    .DOA     (DOA),
    .RVALIDA (RVALIDA),
    .CSB     (CSB),
    .WEB     (WEB),
    .BWB     (BWB),
    .ADDRB   (ADDRB),
    .DIB     (DIB),
    .DOB     (DOB),
    .RVALIDB (RVALIDB),
    .CLRCNT  (CLRCNT),
    .COLL    (COLL),
    .COLLCNT (COLLCNT)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   qc[$];
  exp_t ea, eb;
  int   ec;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents read data or COLL.
  always @(negedge HCLK) begin
    if (RVALIDA) begin
      if (qa.size() == 0) check("rvalida_unexpected", {31'd0, RVALIDA}, 32'd0);
      else begin
        ea = qa.pop_front();
        check("doa_data", DOA, ea.data);
        check("doa_latency", cyc, ea.cyc);
      end
    end else begin
      check("doa_idle_zero", DOA, 32'd0);
      if (qa.size() != 0 && qa[0].cyc < cyc) begin
        check("rvalida_missing", {31'd0, RVALIDA}, 32'd1);
        void'(qa.pop_front());
      end
    end

    if (RVALIDB) begin
      if (qb.size() == 0) check("rvalidb_unexpected", {31'd0, RVALIDB}, 32'd0);
      else begin
        eb = qb.pop_front();
        check("dob_data", DOB, eb.data);
        check("dob_latency", cyc, eb.cyc);
      end
    end else begin
      check("dob_idle_zero", DOB, 32'd0);
      if (qb.size() != 0 && qb[0].cyc < cyc) begin
        check("rvalidb_missing", {31'd0, RVALIDB}, 32'd1);
        void'(qb.pop_front());
      end
    end

    if (COLL) begin
      if (qc.size() == 0) check("coll_unexpected", {31'd0, COLL}, 32'd0);
      else begin
        ec = qc.pop_front();
        check("coll_cycle", cyc, ec);
      end
    end else if (qc.size() != 0 && qc[0] < cyc) begin
      check("coll_missing", {31'd0, COLL}, 32'd1);
      void'(qc.pop_front());
    end
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle();
    CSA = 0; WEA = 0; BWA = '0; ADDRA = '0; DIA = '0;
    CSB = 0; WEB = 0; BWB = '0; ADDRB = '0; DIB = '0;
    CLRCNT = 0;
  endtask

  task automatic wr_a(input logic [AW-1:0] addr, input logic [DW-1:0] d, input logic [NBY-1:0] bw);
    CSA = 1; WEA = 1; BWA = bw; ADDRA = addr; DIA = d;
  endtask

  task automatic wr_b(input logic [AW-1:0] addr, input logic [DW-1:0] d, input logic [NBY-1:0] bw);
    CSB = 1; WEB = 1; BWB = bw; ADDRB = addr; DIB = d;
  endtask

  task automatic rd_a(input logic [AW-1:0] addr, input logic [DW-1:0] expv);
    CSA = 1; WEA = 0; BWA = '0; ADDRA = addr; DIA = '0;
    qa.push_back('{data: expv, cyc: cyc + LAT});
  endtask

  task automatic rd_b(input logic [AW-1:0] addr, input logic [DW-1:0] expv);
    CSB = 1; WEB = 0; BWB = '0; ADDRB = addr; DIB = '0;
    qb.push_back('{data: expv, cyc: cyc + LAT});
  endtask

  task automatic exp_coll();
    qc.push_back(cyc + 1);
  endtask

  initial begin
    idle();
    HRESETn = 1'b0;
    repeat (3) tick();
    check("reset_doa", DOA, 32'd0);
    check("reset_dob", DOB, 32'd0);
    check("reset_rvalida", {31'd0, RVALIDA}, 32'd0);
    check("reset_rvalidb", {31'd0, RVALIDB}, 32'd0);
    check("reset_coll", {31'd0, COLL}, 32'd0);
    check("reset_collcnt", {28'd0, COLLCNT}, 32'd0);
    HRESETn = 1'b1;
    tick();

    // Write on A, read back on B.
    wr_a(16'h2004, 32'hDEADBEEF, 4'hF); tick(); idle();
    rd_b(16'h2004, 32'hDEADBEEF);       tick(); idle();
    repeat (3) tick();

    // Bank isolation: alternating back-to-back reads across banks 0 and 7.
    wr_a(16'h0000, 32'h11111111, 4'hF); tick(); idle();
    wr_a(16'hE000, 32'h22222222, 4'hF); tick(); idle();
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) rd_a(16'h0000, 32'h11111111);
      else            rd_a(16'hE000, 32'h22222222);
      tick(); idle();
    end
    repeat (3) tick();

    // Read-during-write forwarding in both directions.
    wr_a(16'h0010, 32'hAABBCCDD, 4'hF); tick(); idle();
    wr_a(16'h0010, 32'h11223344, 4'h3); rd_b(16'h0010, 32'hAABB3344); tick(); idle();
    wr_b(16'h0010, 32'h55667788, 4'h8); rd_a(16'h0010, 32'h55BB3344); tick(); idle();
    rd_a(16'h0010, 32'h55BB3344); wr_b(16'h0014, 32'hFFFFFFFF, 4'hF); tick(); idle();
    rd_b(16'h0014, 32'hFFFFFFFF); tick(); idle();
    repeat (3) tick();

    // Write/write collision: overlapping lane goes to A.
    wr_a(16'h0030, 32'h00000000, 4'hF); tick(); idle();
    wr_a(16'h0030, 32'hAAAAAAAA, 4'hC); wr_b(16'h0030, 32'hBBBBBBBB, 4'h6); exp_coll();
    tick(); idle();
    check("collcnt_first", {28'd0, COLLCNT}, 32'd1);
    rd_b(16'h0030, 32'hAAAABB00); tick(); idle();
    wr_a(16'h0030, 32'hAAAAAAAA, 4'hC); wr_b(16'h0030, 32'hBBBBBBBB, 4'h3);
    tick(); idle();
    rd_a(16'h0030, 32'hAAAABBBB); tick(); idle();
    check("collcnt_disjoint", {28'd0, COLLCNT}, 32'd1);
    repeat (3) tick();

    // Saturation: 16 more collisions bring the total to 17.
    for (int i = 0; i < 16; i++) begin
      wr_a(16'h0040, i, 4'hF); wr_b(16'h0040, ~i, 4'hF); exp_coll();
      tick();
    end
    idle();
    check("collcnt_saturated", {28'd0, COLLCNT}, 32'hF);
    rd_a(16'h0040, 32'h0000000F); tick(); idle();

    // Clear coinciding with a collision: clear wins.
    wr_a(16'h0050, 32'h1, 4'h1); wr_b(16'h0050, 32'h2, 4'h1); CLRCNT = 1; exp_coll();
    tick(); idle();
    check("collcnt_clear_wins", {28'd0, COLLCNT}, 32'd0);
    wr_a(16'h0050, 32'h1, 4'h1); wr_b(16'h0050, 32'h2, 4'h1); exp_coll();
    tick(); idle();
    check("collcnt_after_clear", {28'd0, COLLCNT}, 32'd1);
    CLRCNT = 1; tick(); idle();
    check("collcnt_clear_only", {28'd0, COLLCNT}, 32'd0);
    wr_a(16'h0050, 32'h1, 4'h1); wr_b(16'h0050, 32'h2, 4'h1); exp_coll();
    tick(); idle();
    check("collcnt_pre_reset", {28'd0, COLLCNT}, 32'd1);
    repeat (2) tick();

    // Asynchronous reset in the cycle after a read aborts it.
    CSA = 1; WEA = 0; ADDRA = 16'h2004;
    tick(); idle();
    HRESETn = 1'b0;
    #1;
    check("abort_rvalida", {31'd0, RVALIDA}, 32'd0);
    check("abort_doa", DOA, 32'd0);
    repeat (3) tick();
    check("abort_rvalida_held", {31'd0, RVALIDA}, 32'd0);
    check("abort_collcnt", {28'd0, COLLCNT}, 32'd0);
    HRESETn = 1'b1;
    tick();
    rd_a(16'h2004, 32'hDEADBEEF); tick(); idle();
    repeat (4) tick();

    check("scoreboard_drained", qa.size() + qb.size() + qc.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
